// File: rtl/fft_frame_buffer.sv
// Ping-pong frame collector feeding the fft_16 core with frozen N-sample frames.
// Optional FFT_FRAME_OFFSET_BIN_EN: treat sample_in as offset-binary ADC code.
module fft_frame_buffer #(
  parameter int WIDTH = 12,
  parameter int N     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 sample_valid,
  input  logic                 fft_done,
  input  logic                 overrun_clr,
  output logic [WIDTH-1:0]     time_samples [N],
  output logic                 start,
  output logic                 busy,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] fill_count
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic             start_q;
  logic             bank_sel_q, bank_sel_d;
  logic             overrun_q, overrun_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0] bank_q [2][N];
  logic [WIDTH-1:0] wdata;
  logic             complete;
  logic             swap;
  logic             drop;

  always_comb begin
`ifdef FFT_FRAME_OFFSET_BIN_EN
    wdata = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
`else
    wdata = sample_in;
`endif
    complete   = sample_valid && (wr_idx_q == IW'(N-1));
    // fft_done frees the FFT in the same cycle, so a coincident frame is taken
    swap       = complete && ((state_q == IDLE) || fft_done);
    drop       = complete && !swap;
    wr_idx_d   = sample_valid ? wr_idx_q + IW'(1) : wr_idx_q;
    bank_sel_d = bank_sel_q ^ swap;
    overrun_d  = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          bank_q[b][i] <= '0;
    end else if (sample_valid) begin
      bank_q[bank_sel_q][wr_idx_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q   <= '0;
      bank_sel_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      bank_sel_q <= bank_sel_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      start_q <= swap;
      unique case (state_q)
        IDLE: if (complete) state_q <= BUSY;
        BUSY: if (fft_done && !complete) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      time_samples[i] = bank_q[~bank_sel_q][i];
  end

  assign start      = start_q;
  assign busy       = (state_q == BUSY);
  assign overrun    = overrun_q;
  assign fill_count = wr_idx_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Randomized bench for fft_frame_buffer against a queue-based frame model.
// Honors FFT_FRAME_OFFSET_BIN_EN when defined.
module tb_fft_frame_buffer;

  localparam int W = 12;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         fft_done = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [W-1:0] time_samples [N];
  logic         start;
  logic         busy;
  logic         overrun;
  logic [3:0]   fill_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] cur [$];
  logic [W-1:0] m_frozen [N];
  logic         m_busy, m_start, m_ovr;

  fft_frame_buffer #(.WIDTH(W), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .fft_done(fft_done),
    .overrun_clr(overrun_clr),
    .time_samples(time_samples),
    .start(start),
    .busy(busy),
    .overrun(overrun),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [N*W-1:0] obs,
                     input logic [N*W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] conv(input logic [W-1:0] s);
`ifdef FFT_FRAME_OFFSET_BIN_EN
    return s ^ (W'(1) << (W-1));
`else
    return s;
`endif
  endfunction

  function automatic logic [N*W-1:0] pk_dut();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = time_samples[i];
    return r;
  endfunction

  function automatic logic [N*W-1:0] pk_model();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m_frozen[i];
    return r;
  endfunction

  task automatic model_reset();
    cur.delete();
    for (int i = 0; i < N; i++) m_frozen[i] = '0;
    m_busy  = 1'b0;
    m_start = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [W-1:0] s,
                              input logic d, input logic c);
    logic compl, drp;
    compl   = v && (cur.size() == N-1);
    drp     = 1'b0;
    m_start = 1'b0;
    if (v) cur.push_back(conv(s));
    if (compl) begin
      if (!m_busy || d) begin
        for (int i = 0; i < N; i++) m_frozen[i] = cur[i];
        m_start = 1'b1;
        m_busy  = 1'b1;
      end else begin
        drp = 1'b1;
      end
      cur.delete();
    end else if (d) begin
      m_busy = 1'b0;
    end
    if (drp) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  task automatic check_all();
    chk("start", start, m_start);
    chk("busy", busy, m_busy);
    chk("overrun", overrun, m_ovr);
    chk("fill_count", fill_count, cur.size());
    chk("frame", pk_dut(), pk_model());
  endtask

  task automatic step(input logic v, input logic [W-1:0] s,
                      input logic d, input logic c);
    sample_valid = v;
    sample_in    = s;
    fft_done     = d;
    overrun_clr  = c;
    @(posedge clk);
    model_update(v, s, d, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    overrun_clr  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_fill", fill_count, 4'd0);
    chk("rst_frame", pk_dut(), '0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // first frame 1..16
    for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("ts0_first", time_samples[0], conv(W'(1)));
    chk("ts15_first", time_samples[N-1], conv(W'(16)));
    step(1'b0, '0, 1'b0, 1'b0);

    // second frame dropped while busy
    for (int i = 17; i <= 32; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    chk("ts0_kept", time_samples[0], conv(W'(1)));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovr_clr", overrun, 1'b0);

    // completion coincident with fft_done
    for (int i = 17; i < 32; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, W'(32), 1'b1, 1'b0);
    chk("sim_start", start, 1'b1);
    chk("sim_busy", busy, 1'b1);
    chk("sim_ts0", time_samples[0], conv(W'(17)));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("idle", busy, 1'b0);

    // gapped stream
    for (int i = 0; i < 2*N; i++)
      step(i[0] == 1'b0, W'(200 + i/2), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef FFT_FRAME_OFFSET_BIN_EN
    step(1'b1, 12'h800, 1'b0, 1'b0);
    step(1'b1, 12'hFFF, 1'b0, 1'b0);
    for (int i = 2; i < N; i++) step(1'b1, 12'h000, 1'b0, 1'b0);
    chk("obin_800", time_samples[0], 12'h000);
    chk("obin_fff", time_samples[1], 12'h7FF);
    step(1'b0, '0, 1'b1, 1'b0);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, W'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);

    // reset mid-frame
    for (int i = 0; i < 7; i++) step(1'b1, W'(50 + i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0);
    chk("mid_ts0", time_samples[0], conv(W'(100)));
    chk("mid_ts15", time_samples[N-1], conv(W'(115)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
